// File: rtl/sc_mult_bi_seq.sv
// Bipolar stochastic multiply sequencer: binary operands in, LFSR-driven
// bitstreams through an XNOR multiplier for one LFSR period, ones count out.

module sc_multiplier_bi (
    input  logic x_i,
    input  logic y_i,
    output logic z_o
);
    assign z_o = ~(x_i ^ y_i);
endmodule

module sc_mult_bi_seq #(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] TAPS   = 8'hB8,
    parameter logic [WIDTH-1:0] SEED_X = 8'h01,
    parameter logic [WIDTH-1:0] SEED_Y = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_count,
    output logic [WIDTH+1:0] out_bi,
    output logic             busy,
    output logic             sx,
    output logic             sy,
    output logic             sz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last cycle index of a run (L-1) and L widened for the bipolar result.
    localparam logic [WIDTH-1:0] LAST  = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH+1:0] L_EXT = {2'b00, {WIDTH{1'b1}}};

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] lfsr_x_q;
    logic [WIDTH-1:0] lfsr_y_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] ones_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_count_q;
    logic [WIDTH+1:0] out_bi_q;

    logic             run;
    logic             sx_w;
    logic             sy_w;
    logic             sz_w;
    logic [WIDTH-1:0] lfsr_x_d;
    logic [WIDTH-1:0] lfsr_y_d;
    logic [WIDTH-1:0] ones_d;
    logic [WIDTH+1:0] bi_d;

    assign run  = (state_q == RUN);
    assign sx_w = run & (lfsr_x_q <= a_q);
    assign sy_w = run & (lfsr_y_q <= b_q);

    sc_multiplier_bi u_mul (
        .x_i (sx_w),
        .y_i (sy_w),
        .z_o (sz_w)
    );

    always_comb begin
        lfsr_x_d = (lfsr_x_q >> 1) ^ (lfsr_x_q[0] ? TAPS : '0);
        lfsr_y_d = (lfsr_y_q >> 1) ^ (lfsr_y_q[0] ? TAPS : '0);
        ones_d   = ones_q + {{(WIDTH-1){1'b0}}, (run & sz_w)};
        bi_d     = {1'b0, ones_q, 1'b0} - L_EXT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            lfsr_x_q    <= SEED_X;
            lfsr_y_q    <= SEED_Y;
            cnt_q       <= '0;
            ones_q      <= '0;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_bi_q    <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= in_a;
                        b_q      <= in_b;
                        lfsr_x_q <= SEED_X;
                        lfsr_y_q <= SEED_Y;
                        cnt_q    <= '0;
                        ones_q   <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    lfsr_x_q <= lfsr_x_d;
                    lfsr_y_q <= lfsr_y_d;
                    ones_q   <= ones_d;
                    cnt_q    <= cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
                    if (cnt_q == LAST) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // First DONE cycle publishes the full count.
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_count_q <= ones_q;
                        out_bi_q    <= bi_d;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = run;
    assign out_valid = out_valid_q;
    assign out_count = out_count_q;
    assign out_bi    = out_bi_q;
    assign sx        = sx_w;
    assign sy        = sy_w;
    assign sz        = run & sz_w;

endmodule
